// File: rtl/dffsnq_pipe_pkg.sv
// rtl/dffsnq_pipe_pkg.sv - shared helpers for the preset-register pipeline
package dffsnq_pipe_pkg;

    localparam int MAX_WIDTH = 1024;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // All-ones in the low `width` bits; callers truncate to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] default_preset(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b < width) v[b] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dffsnq_pipe_if.sv
// rtl/dffsnq_pipe_if.sv - upstream/downstream handshake bundle of the pipeline
interface dffsnq_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q
    );

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q
    );
endinterface

// File: rtl/dffsnq_pipe_stage.sv
// rtl/dffsnq_pipe_stage.sv - one vld+dat register pair with async preset and ready
module dffsnq_pipe_stage #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] PRESET = '1
) (
    input  logic             clk,
    input  logic             setn,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             dn_rdy,
    output logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    // An empty stage can always load, so bubbles are absorbed here.
    assign rdy = !vld || dn_rdy;

    always_ff @(posedge clk or negedge setn) begin
        if (!setn) begin
            vld <= 1'b0;
            dat <= PRESET;
        end else if (rdy) begin
            vld <= up_vld;
            if (up_vld) dat <= up_dat;
        end
    end

endmodule

// File: rtl/dffsnq_pipe.sv
// rtl/dffsnq_pipe.sv - back-pressured preset-register pipeline; optional OCC via DFFSNQ_PIPE_OCC_EN
module dffsnq_pipe
    import dffsnq_pipe_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               DEPTH  = 4,
    parameter logic [WIDTH-1:0] PRESET = WIDTH'(default_preset(WIDTH))
) (
    input  logic                          clk,
    input  logic                          setn,
`ifdef DFFSNQ_PIPE_OCC_EN
    output logic [occ_width(DEPTH)-1:0]   occ,
`endif
    dffsnq_pipe_if.slave                  bus
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;
        logic             dn_rdy;
        logic             stg_rdy;
        logic             stg_vld;
        logic [WIDTH-1:0] stg_dat;

        if (i == 0) begin : g_head
            assign up_vld = bus.in_valid;
            assign up_dat = bus.d;
        end else begin : g_body
            assign up_vld = g_stage[i-1].stg_vld;
            assign up_dat = g_stage[i-1].stg_dat;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = bus.out_ready;
        end else begin : g_mid
            assign dn_rdy = g_stage[i+1].stg_rdy;
        end

        dffsnq_pipe_stage #(
            .WIDTH  (WIDTH),
            .PRESET (PRESET)
        ) u_stage (
            .clk    (clk),
            .setn   (setn),
            .up_vld (up_vld),
            .up_dat (up_dat),
            .dn_rdy (dn_rdy),
            .rdy    (stg_rdy),
            .vld    (stg_vld),
            .dat    (stg_dat)
        );
    end

    assign bus.in_ready  = g_stage[0].stg_rdy;
    assign bus.out_valid = g_stage[DEPTH-1].stg_vld;
    assign bus.q         = g_stage[DEPTH-1].stg_dat;

`ifdef DFFSNQ_PIPE_OCC_EN
    localparam int               OCC_W   = occ_width(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occ_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Tracks popcount(vld): the handshakes are the only ways a word enters or leaves.
    always_ff @(posedge clk or negedge setn) begin
        if (!setn) begin
            occ_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dffsnq_pipe.sv
// tb/tb_dffsnq_pipe.sv - directed vector bench for dffsnq_pipe (DEPTH=4 and DEPTH=1)
module tb_dffsnq_pipe;

    logic clk  = 1'b0;
    logic setn = 1'b0;
    always #5 clk = ~clk;

    dffsnq_pipe_if #(.WIDTH(8)) b4 ();
    dffsnq_pipe_if #(.WIDTH(8)) b1 ();

`ifdef DFFSNQ_PIPE_OCC_EN
    logic [2:0] occ4;
    logic [0:0] occ1;
`endif

    dffsnq_pipe #(.WIDTH(8), .DEPTH(4), .PRESET(8'hFF)) u4 (
        .clk  (clk),
        .setn (setn),
`ifdef DFFSNQ_PIPE_OCC_EN
        .occ  (occ4),
`endif
        .bus  (b4)
    );

    dffsnq_pipe #(.WIDTH(8), .DEPTH(1), .PRESET(8'hFF)) u1 (
        .clk  (clk),
        .setn (setn),
`ifdef DFFSNQ_PIPE_OCC_EN
        .occ  (occ1),
`endif
        .bus  (b1)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       eov;
        logic [7:0] eq;
        logic       eir;
        logic [2:0] eocc;
    } vec_t;

    vec_t tbl [31];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk4(input string tag, input logic eov, input logic [7:0] eq,
                        input logic eir, input logic [2:0] eocc);
        chk({tag, ".out_valid"}, {31'd0, b4.out_valid}, {31'd0, eov});
        chk({tag, ".q"},         {24'd0, b4.q},         {24'd0, eq});
        chk({tag, ".in_ready"},  {31'd0, b4.in_ready},  {31'd0, eir});
`ifdef DFFSNQ_PIPE_OCC_EN
        chk({tag, ".occ"},       {29'd0, occ4},         {29'd0, eocc});
`endif
    endtask

    task automatic drive4(input logic iv, input logic [7:0] d, input logic ordy);
        b4.in_valid  = iv;
        b4.d         = d;
        b4.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming 01..08 with the output always ready
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd1};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd2};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd3};
        tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h01, 1'b1, 3'd4};
        tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 3'd4};
        tbl[5]  = '{1'b1, 8'h06, 1'b1, 1'b1, 8'h03, 1'b1, 3'd4};
        tbl[6]  = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h04, 1'b1, 3'd4};
        tbl[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 8'h05, 1'b1, 3'd4};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 3'd3};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 3'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 3'd1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 1'b1, 3'd0};
        // Fill and stall A0..A5, then drain
        tbl[12] = '{1'b1, 8'hA0, 1'b0, 1'b0, 8'h08, 1'b1, 3'd1};
        tbl[13] = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h08, 1'b1, 3'd2};
        tbl[14] = '{1'b1, 8'hA2, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3};
        tbl[15] = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4};
        tbl[16] = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4};
        tbl[17] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b1, 3'd3};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1, 3'd2};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b1, 3'd1};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1'b1, 3'd0};
        // Full pipeline, same-edge pop of B0 and push of 5A
        tbl[22] = '{1'b1, 8'hB0, 1'b0, 1'b0, 8'hA3, 1'b1, 3'd1};
        tbl[23] = '{1'b1, 8'hB1, 1'b0, 1'b0, 8'hA3, 1'b1, 3'd2};
        tbl[24] = '{1'b1, 8'hB2, 1'b0, 1'b0, 8'hA3, 1'b1, 3'd3};
        tbl[25] = '{1'b1, 8'hB3, 1'b0, 1'b1, 8'hB0, 1'b0, 3'd4};
        tbl[26] = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'hB1, 1'b1, 3'd4};
        tbl[27] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1, 3'd3};
        tbl[28] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 1'b1, 3'd2};
        tbl[29] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 3'd1};
        tbl[30] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 3'd0};

        drive4(1'b0, 8'h00, 1'b0);
        b1.in_valid  = 1'b0;
        b1.d         = 8'h00;
        b1.out_ready = 1'b0;

        #12;
        chk4("reset", 1'b0, 8'hFF, 1'b1, 3'd0);
        @(negedge clk);
        setn = 1'b1;
        tick();

        foreach (tbl[r]) begin
            drive4(tbl[r].iv, tbl[r].d, tbl[r].ordy);
            tick();
            chk4($sformatf("vec%0d", r), tbl[r].eov, tbl[r].eq, tbl[r].eir, tbl[r].eocc);
        end

        // Bubble collapse: C2 trails C1 by three cycles yet settles right behind it
        drive4(1'b1, 8'hC1, 1'b0); tick();
        drive4(1'b0, 8'h00, 1'b0); tick();
        tick();
        drive4(1'b1, 8'hC2, 1'b0); tick();
        chk4("bub_push2", 1'b1, 8'hC1, 1'b1, 3'd2);
        drive4(1'b0, 8'h00, 1'b0); tick();
        tick();
        chk4("bub_settled", 1'b1, 8'hC1, 1'b1, 3'd2);
        drive4(1'b0, 8'h00, 1'b1); tick();
        chk4("bub_next", 1'b1, 8'hC2, 1'b1, 3'd1);
        tick();
        chk4("bub_empty", 1'b0, 8'hC2, 1'b1, 3'd0);

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 8'hD0 + 8'(k), 1'b1);
            tick();
        end
        chk4("pre_rst", 1'b1, 8'hD0, 1'b1, 3'd4);
        setn = 1'b0;
        #1;
        chk4("async_rst", 1'b0, 8'hFF, 1'b1, 3'd0);
        drive4(1'b0, 8'h00, 1'b0);
        #1;
        setn = 1'b1;
        tick();
        chk4("post_rst", 1'b0, 8'hFF, 1'b1, 3'd0);

        // DEPTH=1: X on D with no valid must not leak into the register
        b1.d         = 8'hxx;
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        tick();
        chk("d1_x_ov", {31'd0, b1.out_valid}, 32'd0);
        chk("d1_x_q",  {24'd0, b1.q},         32'hFF);
        b1.d        = 8'h3C;
        b1.in_valid = 1'b1;
        tick();
        chk("d1_push_ov", {31'd0, b1.out_valid}, 32'd1);
        chk("d1_push_q",  {24'd0, b1.q},         32'h3C);
        b1.d         = 8'h44;
        b1.out_ready = 1'b0;
        #1;
        chk("d1_full_ir", {31'd0, b1.in_ready}, 32'd0);
        tick();
        chk("d1_hold_q", {24'd0, b1.q}, 32'h3C);
        b1.d         = 8'hxx;
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        chk("d1_pop_ov", {31'd0, b1.out_valid}, 32'd0);
        chk("d1_pop_q",  {24'd0, b1.q},         32'h3C);
        chk("d1_pop_ir", {31'd0, b1.in_ready},  32'd1);
`ifdef DFFSNQ_PIPE_OCC_EN
        chk("d1_pop_occ", {31'd0, occ1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
